// File: rtl/ram_mbist_ctrl_if.sv
// Host, RAM and BIST control/status bundle for ram_mbist_ctrl.
// master = the controller, slave = whoever drives start/host and owns the RAM.
interface ram_mbist_ctrl_if #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 8
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [ADDRWIDTH-1:0] fail_addr;
  logic [DATAWIDTH-1:0] fail_exp;
  logic [DATAWIDTH-1:0] fail_got;
  logic [CNTWIDTH-1:0]  err_cnt;

  logic                 host_cs;
  logic                 host_we;
  logic                 host_oe;
  logic [ADDRWIDTH-1:0] host_addr;
  logic [DATAWIDTH-1:0] host_wdata;

  logic                 ram_cs;
  logic                 ram_we;
  logic                 ram_oe;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic [DATAWIDTH-1:0] ram_wdata;
  logic [DATAWIDTH-1:0] ram_rdata;

  modport master (
    input  start, host_cs, host_we, host_oe, host_addr, host_wdata, ram_rdata,
    output busy, done, fail, fail_addr, fail_exp, fail_got, err_cnt,
           ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );

  modport slave (
    output start, host_cs, host_we, host_oe, host_addr, host_wdata, ram_rdata,
    input  busy, done, fail, fail_addr, fail_exp, fail_got, err_cnt,
           ram_cs, ram_we, ram_oe, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_mbist_ctrl.sv
// March C- MBIST controller and host/BIST RAM mux; a run takes 15*SIZE cycles, no backpressure.
// Define MBIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module ram_mbist_ctrl #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16,
  parameter int CNTWIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_mbist_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
  } state_t;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_CMP} op_t;

  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(SIZE - 1);
  localparam logic [DATAWIDTH-1:0] D0   = '0;
  localparam logic [DATAWIDTH-1:0] D1   = '1;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 cs_q, cs_d, we_q, we_d, oe_q, oe_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 busy_q, done_q, fail_q;
  logic [ADDRWIDTH-1:0] fail_addr_q;
  logic [DATAWIDTH-1:0] fail_exp_q, fail_got_q;
  logic [CNTWIDTH-1:0]  err_cnt_q;
  logic                 running, mismatch, start_ok, stop;

  function automatic logic is_run(state_t s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

  function automatic logic is_up(state_t s);
    return (s == S_M0) || (s == S_M1) || (s == S_M2);
  endfunction

  function automatic logic has_wr(state_t s);
    return is_run(s) && (s != S_M5);
  endfunction

  function automatic logic [DATAWIDTH-1:0] rd_val(state_t s);
    return ((s == S_M2) || (s == S_M4)) ? D1 : D0;
  endfunction

  function automatic logic [DATAWIDTH-1:0] wr_val(state_t s);
    return ((s == S_M1) || (s == S_M3)) ? D1 : D0;
  endfunction

  function automatic logic [ADDRWIDTH-1:0] first_addr(state_t s);
    return is_up(s) ? '0 : LAST;
  endfunction

  function automatic logic [ADDRWIDTH-1:0] last_addr(state_t s);
    return is_up(s) ? LAST : '0;
  endfunction

  always_comb begin
    state_t nxt;
    logic   adv;
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    nxt      = S_IDLE;
    adv      = 1'b0;
    running  = is_run(state_q);
    mismatch = running && (op_q == OP_CMP) && (bus.ram_rdata != rd_val(state_q));
    start_ok = bus.start && !running;
`ifdef MBIST_STOP_ON_FAIL_EN
    stop     = mismatch;
`else
    stop     = 1'b0;
`endif

    if (start_ok) begin
      state_d = S_M0;
      op_d    = OP_WR;
      addr_d  = '0;
    end else if (running) begin
      if (stop) begin
        state_d = S_DONE;
      end else begin
        unique case (op_q)
          OP_RD:   op_d = OP_CMP;
          OP_CMP:  if (has_wr(state_q)) op_d = OP_WR; else adv = 1'b1;
          default: adv = 1'b1;
        endcase
        if (adv) begin
          if (addr_q == last_addr(state_q)) begin
            if (state_q == S_M5) begin
              state_d = S_DONE;
            end else begin
              // every element after M0 opens with a read
              nxt     = state_t'(state_q + 4'd1);
              state_d = nxt;
              addr_d  = first_addr(nxt);
              op_d    = OP_RD;
            end
          end else begin
            addr_d = is_up(state_q) ? addr_q + ADDRWIDTH'(1) : addr_q - ADDRWIDTH'(1);
            op_d   = (state_q == S_M0) ? OP_WR : OP_RD;
          end
        end
      end
    end

    cs_d    = is_run(state_d) && (op_d != OP_CMP);
    we_d    = is_run(state_d) && (op_d == OP_WR);
    oe_d    = is_run(state_d) && (op_d == OP_RD);
    wdata_d = we_d ? wr_val(state_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      wdata_q <= wdata_d;
      busy_q  <= is_run(state_d);
      done_q  <= (state_d == S_DONE);
      if (start_ok) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_exp_q  <= '0;
        fail_got_q  <= '0;
        err_cnt_q   <= '0;
      end else if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNTWIDTH'(1);
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= addr_q;
          fail_exp_q  <= rd_val(state_q);
          fail_got_q  <= bus.ram_rdata;
        end
      end
    end
  end

  assign bus.ram_cs    = busy_q ? cs_q    : bus.host_cs;
  assign bus.ram_we    = busy_q ? we_q    : bus.host_we;
  assign bus.ram_oe    = busy_q ? oe_q    : bus.host_oe;
  assign bus.ram_addr  = busy_q ? addr_q  : bus.host_addr;
  assign bus.ram_wdata = busy_q ? wdata_q : bus.host_wdata;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_exp  = fail_exp_q;
  assign bus.fail_got  = fail_got_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ram_mbist_ctrl.sv
// Bench for ram_mbist_ctrl: behavioural RAM with an injectable stuck-at bit,
// and a March C- reference that predicts the op stream, run length and diagnostics.
module tb_ram_mbist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SZ = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_mbist_ctrl_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .CNTWIDTH(CW)) bus();

  ram_mbist_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SIZE(SZ), .CNTWIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit         we;
    int         addr;
    logic [7:0] dat;
  } op_s;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [SZ];
  bit         f_en   = 1'b0;
  int         f_addr = 0;
  int         f_bit  = 0;
  bit         f_val  = 1'b0;

  op_s obs_q[$];
  op_s exp_q[$];
  op_s mon_op;

  int         m_err    = 0;
  int         m_cycles = 0;
  bit         m_fail   = 1'b0;
  int         m_faddr  = 0;
  logic [7:0] m_fexp   = 8'h00;
  logic [7:0] m_fgot   = 8'h00;

  function automatic logic [7:0] fault_rd(int a, logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.ram_rdata <= 8'h00;
    end else begin
      if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_cs && !bus.ram_we && bus.ram_oe)
        bus.ram_rdata <= fault_rd(int'(bus.ram_addr), mem[bus.ram_addr]);
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.busy && bus.ram_cs) begin
      mon_op.we   = bus.ram_we;
      mon_op.addr = int'(bus.ram_addr);
      mon_op.dat  = bus.ram_we ? bus.ram_wdata : 8'h00;
      obs_q.push_back(mon_op);
    end
  end

  // March C- over a model memory seen through the same fault
  task automatic build_model();
    logic [7:0] mm [SZ];
    int  upv [6] = '{1, 1, 1, 0, 0, 0};
    int  rv  [6] = '{-1, 0, 1, 0, 1, 0};
    int  wv  [6] = '{0, 1, 0, 1, 0, -1};
    bit  stop;
    op_s o;
    stop = 1'b0;
    exp_q.delete();
    m_err = 0; m_cycles = 0; m_fail = 1'b0; m_faddr = 0; m_fexp = 8'h00; m_fgot = 8'h00;
    for (int e = 0; e < 6 && !stop; e++) begin
      for (int i = 0; i < SZ && !stop; i++) begin
        int a;
        a = (upv[e] != 0) ? i : SZ - 1 - i;
        if (rv[e] >= 0) begin
          logic [7:0] ex, g;
          ex = (rv[e] != 0) ? 8'hFF : 8'h00;
          g  = fault_rd(a, mm[a]);
          o.we = 1'b0; o.addr = a; o.dat = 8'h00;
          exp_q.push_back(o);
          m_cycles += 2;
          if (g !== ex) begin
            if (m_err < (1 << CW) - 1) m_err++;
            if (!m_fail) begin
              m_fail = 1'b1; m_faddr = a; m_fexp = ex; m_fgot = g;
            end
`ifdef MBIST_STOP_ON_FAIL_EN
            stop = 1'b1;
`endif
          end
        end
        if (wv[e] >= 0 && !stop) begin
          o.we = 1'b1; o.addr = a; o.dat = (wv[e] != 0) ? 8'hFF : 8'h00;
          exp_q.push_back(o);
          m_cycles += 1;
          mm[a] = o.dat;
        end
      end
    end
  endtask

  task automatic run_test(input string name, input bit extra_start);
    int k, bad;
    bit seen;
    build_model();
    obs_q.delete();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.fail !== 1'b0 || bus.err_cnt !== '0) begin
      n_fail++;
      $display("FAIL %s_start: busy=%b done=%b fail=%b err=%0d, want 1 0 0 0",
               name, bus.busy, bus.done, bus.fail, bus.err_cnt);
    end
    seen = 1'b0;
    for (k = 1; k <= 400; k++) begin
      if (extra_start && k == 50) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin seen = 1'b1; break; end
    end
    n_tests++;
    if (!seen || k != m_cycles) begin
      n_fail++;
      $display("FAIL %s_done_edge: done after %0d edges (seen=%b), want %0d", name, k, seen, m_cycles);
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.fail !== m_fail || bus.err_cnt !== CW'(m_err)) begin
      n_fail++;
      $display("FAIL %s_status: busy=%b fail=%b err=%0d, want 0 %b %0d",
               name, bus.busy, bus.fail, bus.err_cnt, m_fail, m_err);
    end
    n_tests++;
    if (bus.fail_addr !== AW'(m_faddr) || bus.fail_exp !== m_fexp || bus.fail_got !== m_fgot) begin
      n_fail++;
      $display("FAIL %s_capture: addr=%0d exp=%h got=%h, want %0d %h %h",
               name, bus.fail_addr, bus.fail_exp, bus.fail_got, m_faddr, m_fexp, m_fgot);
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_op_count: %0d ops, want %0d", name, obs_q.size(), exp_q.size());
    end
    bad = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (bad < 0 && (obs_q[i].we !== exp_q[i].we || obs_q[i].addr != exp_q[i].addr ||
                      obs_q[i].dat !== exp_q[i].dat)) bad = i;
    end
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_op_seq: op %0d is we=%b a=%0d d=%h, want we=%b a=%0d d=%h", name, bad,
               obs_q[bad].we, obs_q[bad].addr, obs_q[bad].dat,
               exp_q[bad].we, exp_q[bad].addr, exp_q[bad].dat);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs_q.size() != exp_q.size() || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_after_done: ops=%0d done=%b, want %0d 1", name, obs_q.size(), bus.done, exp_q.size());
    end
  endtask

  task automatic drive_host_random();
    bus.host_cs    = 1'($urandom);
    bus.host_we    = 1'($urandom);
    bus.host_oe    = 1'($urandom);
    bus.host_addr  = AW'($urandom);
    bus.host_wdata = DW'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.host_cs = 1'b1; bus.host_we = 1'b0; bus.host_oe = 1'b1;
    bus.host_addr = 4'h3; bus.host_wdata = 8'h5C;
    #3;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fail !== 1'b0 || bus.err_cnt !== '0 ||
        bus.fail_addr !== '0 || bus.fail_exp !== '0 || bus.fail_got !== '0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b fail=%b err=%0d fa=%0d fe=%h fg=%h, want all 0",
               bus.busy, bus.done, bus.fail, bus.err_cnt, bus.fail_addr, bus.fail_exp, bus.fail_got);
    end
    n_tests++;
    if (bus.ram_cs !== 1'b1 || bus.ram_oe !== 1'b1 || bus.ram_addr !== 4'h3 || bus.ram_wdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL reset_mux: cs=%b oe=%b a=%h d=%h, want 1 1 3 5c",
               bus.ram_cs, bus.ram_oe, bus.ram_addr, bus.ram_wdata);
    end
    bus.host_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive_host_random();
      bus.host_we = 1'b0;
      #2;
      if (bus.ram_cs !== bus.host_cs || bus.ram_we !== bus.host_we || bus.ram_oe !== bus.host_oe ||
          bus.ram_addr !== bus.host_addr || bus.ram_wdata !== bus.host_wdata) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bypass_mirror: %0d of 20 cycles differ from host, want 0", bad);
    end
    @(posedge clk); #1;
    bus.host_cs = 1'b1; bus.host_we = 1'b1; bus.host_oe = 1'b0;
    bus.host_addr = 4'd9; bus.host_wdata = 8'hA5;
    @(posedge clk); #1;
    bus.host_we = 1'b0; bus.host_oe = 1'b1; bus.host_wdata = 8'h00;
    @(posedge clk); #1;
    bus.host_cs = 1'b0; bus.host_oe = 1'b0;
    n_tests++;
    if (bus.ram_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL bypass_rw: read %h from addr 9, want a5", bus.ram_rdata);
    end
    n_tests++;
    if (bus.busy !== 1'b0 || bus.fail !== m_fail || bus.err_cnt !== CW'(m_err) ||
        bus.fail_addr !== AW'(m_faddr) || bus.fail_got !== m_fgot) begin
      n_fail++;
      $display("FAIL bypass_status: busy=%b fail=%b err=%0d fa=%0d fg=%h, want 0 %b %0d %0d %h",
               bus.busy, bus.fail, bus.err_cnt, bus.fail_addr, bus.fail_got, m_fail, m_err, m_faddr, m_fgot);
    end
  endtask

  task automatic test_fault_free();
    f_en = 1'b0;
    run_test("fault_free", 1'b1);
  endtask

  task automatic test_stuck_bit3_addr5();
    int want_err;
    f_en = 1'b1; f_addr = 5; f_bit = 3; f_val = 1'b1;
    run_test("stuck_a5b3", 1'b0);
`ifdef MBIST_STOP_ON_FAIL_EN
    want_err = 1;
`else
    want_err = 3;
`endif
    n_tests++;
    if (bus.err_cnt !== CW'(want_err) || bus.fail_addr !== 4'd5 ||
        bus.fail_exp !== 8'h00 || bus.fail_got !== 8'h08) begin
      n_fail++;
      $display("FAIL stuck_a5b3_known: err=%0d fa=%0d fe=%h fg=%h, want %0d 5 00 08",
               bus.err_cnt, bus.fail_addr, bus.fail_exp, bus.fail_got, want_err);
    end
    f_en = 1'b0;
  endtask

  task automatic test_restart();
    f_en = 1'b0;
    run_test("restart", 1'b0);
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 3; i++) begin
      f_en   = 1'b1;
      f_addr = int'($urandom_range(0, SZ - 1));
      f_bit  = int'($urandom_range(0, 7));
      f_val  = 1'($urandom_range(0, 1));
      run_test($sformatf("rand_fault%0d", i), 1'b0);
    end
    f_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    drive_host_random();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.fail !== 1'b0 || bus.err_cnt !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset_status: busy=%b done=%b fail=%b err=%0d, want 0 0 0 0",
               bus.busy, bus.done, bus.fail, bus.err_cnt);
    end
    n_tests++;
    if (bus.ram_cs !== bus.host_cs || bus.ram_we !== bus.host_we || bus.ram_oe !== bus.host_oe ||
        bus.ram_addr !== bus.host_addr || bus.ram_wdata !== bus.host_wdata) begin
      n_fail++;
      $display("FAIL midrun_reset_mux: ram cs%b we%b oe%b a%h d%h, want host cs%b we%b oe%b a%h d%h",
               bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_addr, bus.ram_wdata,
               bus.host_cs, bus.host_we, bus.host_oe, bus.host_addr, bus.host_wdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    bus.host_cs = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_idle: busy=%b done=%b after release, want 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    bus.host_we = 1'b0; bus.host_oe = 1'b0;
    test_reset();
    test_bypass();
    test_fault_free();
    test_stuck_bit3_addr5();
    test_bypass();
    test_restart();
    test_random_faults();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_mbist_ctrl.md
Name: ram_mbist_ctrl

Overview:
- March C- memory built-in self-test (MBIST) controller and access mux.
- Sits directly upstream of the single-port RAM core and drives its cs/we/oe/addr/data interface.
- While idle, host access signals pass straight through to the RAM. On start, the block takes over the RAM, runs March C- over addresses 0..SIZE-1 and reports pass/fail with first-failure diagnostics.

Parameters:
ADDRWIDTH, 4, RAM address width
DATAWIDTH, 8, RAM word width
SIZE, 16, number of words tested (addresses 0..SIZE-1; SIZE <= 2**ADDRWIDTH)
CNTWIDTH, 8, error counter width (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; starts test when idle
busy  out  1  test in progress; RAM owned by BIST
done  out  1  test finished; held until next start
fail  out  1  at least one mismatch seen (valid when done)
fail_addr  out  ADDRWIDTH  address of first mismatch
fail_exp  out  DATAWIDTH  expected word at first mismatch
fail_got  out  DATAWIDTH  read word at first mismatch
err_cnt  out  CNTWIDTH  mismatch count, saturates at all-ones
host_cs, host_we, host_oe  in  1 each  host strobes
host_addr  in  ADDRWIDTH  host address
host_wdata  in  DATAWIDTH  host write data
ram_cs, ram_we, ram_oe  out  1 each  RAM strobes
ram_addr  out  ADDRWIDTH  RAM address
ram_wdata  out  DATAWIDTH  RAM write data (drives inout when oe low)
ram_rdata  in  DATAWIDTH  RAM read data

Behaviour:
- RAM model:
  - Write is committed at the clk edge with cs=1, we=1.
  - Read is a cycle with cs=1, we=0, oe=1. ram_rdata is valid in the following cycle.
- Mux:
  - busy=0: ram_* = host_* combinationally.
  - busy=1: ram_* come from BIST registers. Host inputs are ignored.
- Reset (async, rst_n=0): state IDLE.
  - busy=0, done=0, fail=0; fail_addr, fail_exp, fail_got and err_cnt are 0.
  - BIST strobe registers are 0.
- States:
  - IDLE -> M0 on start.
  - M0..M5 run the March elements.
  - M0..M5 -> DONE after the last compare.
  - DONE -> M0 on start.
- March elements (D0 = all zeros, D1 = all ones):
  - M0: up, w0.
  - M1: up, r0 then w1.
  - M2: up, r1 then w0.
  - M3: down, r0 then w1.
  - M4: down, r1 then w0.
  - M5: down, r0.
- Address sequencing: "up" runs 0..SIZE-1; "down" runs SIZE-1..0. No wrap beyond SIZE-1.
- Timing:
  - Write op: 1 cycle.
  - Read op: 2 cycles (issue, then compare with ram_oe=0 and cs=0).
  - Total run is 15*SIZE cycles.
  - busy rises on the edge that samples start. The first RAM op is driven in that cycle.
  - done=1 and busy=0 after exactly 15*SIZE+1 edges, counting from the start edge.
- Compare: in the compare cycle, ram_rdata != expected is a mismatch.
  - err_cnt increments on each mismatch, saturating.
  - On the first mismatch only, fail is set and fail_addr, fail_exp and fail_got are captured.
- A new start from IDLE or DONE clears done, fail, err_cnt and the capture registers in the same edge.
- start while busy=1 is ignored.
- rst_n asserted mid-test: immediate return to IDLE with reset values; RAM contents are undefined.
- SIZE=1: every element runs on address 0 only. Total is 15 cycles.

Optional Feature:
- Macro: MBIST_STOP_ON_FAIL_EN.
- Defined: on the first mismatch the FSM goes to DONE at the next edge.
  - done=1 and busy=0 at that edge.
  - err_cnt=1.
  - No further RAM ops are issued.
- Undefined: the test always runs to completion and err_cnt counts all mismatches.

Test Plan:
- Fault-free RAM, SIZE=16:
  - Pulse start -> busy for 240 cycles; done=1, fail=0, err_cnt=0 at edge 241.
  - Op count: 160 RAM ops (80 writes, 80 reads), addresses in the order above.
- Stuck-at-1 on bit 3 of address 5 (feature off):
  - Mismatches occur on r0 in M1, M3 and M5 -> fail=1, err_cnt=3.
  - First capture: fail_addr=5, fail_exp=0x00, fail_got=0x08.
- Same fault with MBIST_STOP_ON_FAIL_EN:
  - done is asserted on the edge after the M1 compare at address 5 -> err_cnt=1, no RAM op afterward.
- Reset mid-run: rst_n=0 at cycle 100 -> busy, done, fail and err_cnt are all 0 immediately; ram_* follow host_*.
- Extra starts:
  - start pulsed at cycle 50 while busy -> no effect; done still at edge 241.
  - start while DONE -> done clears and a new run begins.
- Bypass while idle: host write 0xA5 to address 9, then host read -> ram_* mirror host_* each cycle; BIST outputs unchanged.
